// File: rtl/vbuf_pkg.sv
// Shared frame geometry and writer state type for the video buffer path.
// The scan column decoder and data mux import the same constants.
package vbuf_pkg;

    localparam int FRAME_COLS = 8;
    localparam int COL_BITS   = 8;
    localparam int VBUF_W     = 64;
    localparam int PTR_W      = 3;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } vbuf_wr_state_t;

    // Returns word with the byte lane of column col replaced by data.
    function automatic logic [VBUF_W-1:0] merge_col(
        input logic [VBUF_W-1:0]   word,
        input logic [PTR_W-1:0]    col,
        input logic [COL_BITS-1:0] data
    );
        logic [VBUF_W-1:0] result;
        result = word;
        result[int'(col)*COL_BITS +: COL_BITS] = data;
        return result;
    endfunction

endpackage

// File: rtl/vbuf_bank.sv
// 64-bit frame register with a byte-lane write by column index and a
// whole-word load; the load takes priority when both are requested.
module vbuf_bank
    import vbuf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [PTR_W-1:0]    wr_col_i,
    input  logic [COL_BITS-1:0] wr_data_i,
    input  logic                load_en_i,
    input  logic [VBUF_W-1:0]   load_data_i,
    output logic [VBUF_W-1:0]   data_o
);

    logic [VBUF_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (load_en_i) begin
            word_q <= load_data_i;
        end else if (wr_en_i) begin
            word_q <= merge_col(word_q, wr_col_i, wr_data_i);
        end
    end

    assign data_o = word_q;

endmodule

// File: rtl/vbuf_writer.sv
// Assembles 8 column bytes into a back buffer and swaps them into the front
// buffer. VBUF_WRITER_SYNC_SWAP_EN holds swaps until the next scan_wrap.
module vbuf_writer
    import vbuf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [COL_BITS-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_sof,
    output logic                in_ready,
    input  logic                scan_wrap,
    output logic [VBUF_W-1:0]   vbuf,
    output logic                frame_swapped,
    output logic [PTR_W-1:0]    wr_ptr
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  wr_col;
    logic              xfer;
    logic              frame_done;
    logic              swap;
    logic              frame_swapped_q;
    logic [VBUF_W-1:0] back_word;
    logic [VBUF_W-1:0] front_word;
    logic [VBUF_W-1:0] front_load_data;

    assign wr_col     = in_sof ? '0 : wr_ptr_q;
    assign xfer       = in_valid && in_ready;
    assign frame_done = xfer && (wr_col == PTR_W'(FRAME_COLS - 1));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (xfer) begin
            wr_ptr_d = wr_col + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            frame_swapped_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            frame_swapped_q <= swap;
        end
    end

`ifdef VBUF_WRITER_SYNC_SWAP_EN
    vbuf_wr_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // A wrap coinciding with frame completion is seen while still in FILL,
    // so the swap naturally waits for the following wrap.
    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        if (state_q == FILL) begin
            if (frame_done) begin
                state_d = PENDING;
            end
        end else begin
            if (scan_wrap) begin
                swap    = 1'b1;
                state_d = FILL;
            end
        end
    end

    assign in_ready        = !rst && (state_q == FILL);
    assign front_load_data = back_word;
`else
    logic unused_scan_wrap;

    assign unused_scan_wrap = scan_wrap;
    assign swap             = frame_done;
    assign in_ready         = !rst;
    // The column-7 byte is still in flight, so merge it into the swapped word.
    assign front_load_data  = merge_col(back_word, wr_col, in_data);
`endif

    vbuf_bank u_back (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (xfer),
        .wr_col_i    (wr_col),
        .wr_data_i   (in_data),
        .load_en_i   (1'b0),
        .load_data_i ('0),
        .data_o      (back_word)
    );

    vbuf_bank u_front (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (1'b0),
        .wr_col_i    ('0),
        .wr_data_i   ('0),
        .load_en_i   (swap),
        .load_data_i (front_load_data),
        .data_o      (front_word)
    );

    assign vbuf          = front_word;
    assign frame_swapped = frame_swapped_q;
    assign wr_ptr        = wr_ptr_q;

endmodule

// File: tb/tb_vbuf_writer.sv
// Self-checking bench for vbuf_writer: directed vector table for the build
// selected by VBUF_WRITER_SYNC_SWAP_EN, then a scoreboarded random-gap run.
module tb_vbuf_writer;

`ifdef VBUF_WRITER_SYNC_SWAP_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    localparam logic [63:0] F1 = 64'h0807060504030201;
    localparam logic [63:0] F2 = 64'h77665544332211AA;
    localparam logic [63:0] F3 = 64'h1716151413121110;
    localparam logic [63:0] F4 = 64'h1F1E1D1C1B1A1918;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic        scan_wrap;
    logic [63:0] vbuf;
    logic        frame_swapped;
    logic [2:0]  wr_ptr;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        sof;
        logic [7:0]  data;
        logic        wrap;
        logic        expReady;
        logic [2:0]  expPtr;
        logic        expSwapped;
        logic [63:0] expVbuf;
    } vec_t;

    vec_t vecs[$];

    vbuf_writer dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_sof        (in_sof),
        .in_ready      (in_ready),
        .scan_wrap     (scan_wrap),
        .vbuf          (vbuf),
        .frame_swapped (frame_swapped),
        .wr_ptr        (wr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(input logic r, input logic v, input logic s,
                                   input logic [7:0] d, input logic w,
                                   input logic rdy, input logic [2:0] ptr,
                                   input logic sw, input logic [63:0] vb);
        vec_t x;
        x.rst = r; x.valid = v; x.sof = s; x.data = d; x.wrap = w;
        x.expReady = rdy; x.expPtr = ptr; x.expSwapped = sw; x.expVbuf = vb;
        vecs.push_back(x);
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        in_valid  = v.valid;
        in_sof    = v.sof;
        in_data   = v.data;
        scan_wrap = v.wrap;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    initial begin : main
        logic [63:0] mBack, mFront;
        logic [2:0]  mPtr;
        logic        mPending, expReady, xfer, swapNow;
        int          framesModel, swapsSeen;

        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; scan_wrap = 1'b0;

        // Reset, including a valid byte that must be ignored.
        addVec(1, 0, 0, 8'h00, 0, 0, 3'd0, 0, 64'h0);
        addVec(1, 1, 0, 8'hFF, 0, 0, 3'd0, 0, 64'h0);
`ifdef VBUF_WRITER_SYNC_SWAP_EN
        for (int i = 1; i <= 8; i++)
            addVec(0, 1, 0, 8'(i), 0, 1, 3'(i % 8), 0, 64'h0);
        for (int i = 0; i < 4; i++)
            addVec(0, 1, 0, 8'hFF, 0, 0, 3'd0, 0, 64'h0);
        addVec(0, 0, 0, 8'h00, 1, 0, 3'd0, 1, F1);
        addVec(0, 0, 1, 8'hEE, 1, 1, 3'd0, 0, F1);
        addVec(0, 1, 0, 8'hA1, 0, 1, 3'd1, 0, F1);
        addVec(0, 1, 0, 8'hA2, 0, 1, 3'd2, 0, F1);
        addVec(0, 1, 0, 8'hA3, 0, 1, 3'd3, 0, F1);
        addVec(0, 1, 1, 8'hAA, 0, 1, 3'd1, 0, F1);
        for (int i = 1; i <= 6; i++)
            addVec(0, 1, 0, 8'(i * 17), (i == 3), 1, 3'(i + 1), 0, F1);
        addVec(0, 1, 0, 8'h77, 1, 1, 3'd0, 0, F1);
        addVec(0, 1, 0, 8'hFF, 0, 0, 3'd0, 0, F1);
        addVec(0, 0, 0, 8'h00, 1, 0, 3'd0, 1, F2);
        addVec(0, 0, 0, 8'h00, 0, 1, 3'd0, 0, F2);
        for (int i = 0; i < 8; i++)
            addVec(0, 1, 0, 8'(8'h10 + i), 0, 1, 3'((i + 1) % 8), 0, F2);
        addVec(1, 0, 0, 8'h00, 1, 0, 3'd0, 0, 64'h0);
        addVec(0, 0, 0, 8'h00, 1, 1, 3'd0, 0, 64'h0);
        addVec(0, 0, 0, 8'h00, 0, 1, 3'd0, 0, 64'h0);
`else
        for (int i = 1; i <= 8; i++)
            addVec(0, 1, 0, 8'(i), 0, 1, 3'(i % 8), (i == 8), (i == 8) ? F1 : 64'h0);
        addVec(0, 0, 1, 8'hEE, 1, 1, 3'd0, 0, F1);
        addVec(0, 1, 0, 8'hA1, 0, 1, 3'd1, 0, F1);
        addVec(0, 1, 0, 8'hA2, 0, 1, 3'd2, 0, F1);
        addVec(0, 1, 0, 8'hA3, 0, 1, 3'd3, 0, F1);
        addVec(0, 1, 1, 8'hAA, 0, 1, 3'd1, 0, F1);
        for (int i = 1; i <= 6; i++)
            addVec(0, 1, 0, 8'(i * 17), (i == 3), 1, 3'(i + 1), 0, F1);
        addVec(0, 1, 0, 8'h77, 0, 1, 3'd0, 1, F2);
        for (int k = 0; k < 16; k++)
            addVec(0, 1, 0, 8'(8'h10 + k), 0, 1, 3'((k + 1) % 8),
                   (k == 7 || k == 15), (k < 7) ? F2 : ((k < 15) ? F3 : F4));
        addVec(0, 1, 0, 8'hC1, 0, 1, 3'd1, 0, F4);
        addVec(0, 1, 0, 8'hC2, 0, 1, 3'd2, 0, F4);
        addVec(1, 1, 0, 8'hC3, 0, 0, 3'd0, 0, 64'h0);
        addVec(0, 0, 0, 8'h00, 0, 1, 3'd0, 0, 64'h0);
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_in_ready", i), {63'b0, in_ready}, {63'b0, vecs[i].expReady});
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_wr_ptr", i), {61'b0, wr_ptr}, {61'b0, vecs[i].expPtr});
            checkOutput($sformatf("v%0d_frame_swapped", i), {63'b0, frame_swapped}, {63'b0, vecs[i].expSwapped});
            checkOutput($sformatf("v%0d_vbuf", i), vbuf, vecs[i].expVbuf);
        end

        // Random valid gaps with scan_wrap every 8 cycles, against a small model.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; scan_wrap = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mBack = '0; mFront = '0; mPtr = '0; mPending = 1'b0;
        framesModel = 0; swapsSeen = 0;
        for (int cyc = 0; cyc < 240; cyc++) begin
            if (cyc > 0) @(negedge clk);
            in_valid  = (cyc < 216) ? ($urandom_range(0, 2) != 0) : 1'b0;
            in_data   = 8'($urandom);
            in_sof    = 1'b0;
            scan_wrap = ((cyc % 8) == 7);
            expReady  = SYNC ? !mPending : 1'b1;
            #1;
            checkOutput("rnd_in_ready", {63'b0, in_ready}, {63'b0, expReady});
            xfer    = in_valid && expReady;
            swapNow = 1'b0;
            if (SYNC && mPending && scan_wrap) begin
                mFront   = mBack;
                mPending = 1'b0;
                swapNow  = 1'b1;
            end
            if (xfer) begin
                mBack[{mPtr, 3'b000} +: 8] = in_data;
                if (mPtr == 3'd7) begin
                    framesModel++;
                    if (SYNC) begin
                        mPending = 1'b1;
                    end else begin
                        mFront  = mBack;
                        swapNow = 1'b1;
                    end
                end
                mPtr = mPtr + 3'd1;
            end
            @(posedge clk);
            #1;
            checkOutput("rnd_vbuf", vbuf, mFront);
            checkOutput("rnd_frame_swapped", {63'b0, frame_swapped}, {63'b0, swapNow});
            if (frame_swapped) swapsSeen++;
        end
        checkOutput("rnd_frame_count", 64'(swapsSeen), 64'(framesModel));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/vbuf_writer.md
# vbuf_writer

Loads display frames into the 64-bit video buffer that the column-scan mux reads. Accepts a byte stream over a valid/ready handshake, assembles eight column bytes in a back buffer, and swaps the completed frame into the front buffer, by default only at a scan wrap so a frame never tears mid-scan. It sits between the host/input pins and the column scan logic, driving its `vbuf` input.

## Interface
- No parameters; frame geometry (8 columns x 8 bits) is fixed.
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  8  column byte; bit n = row n of the addressed column
- `in_valid`  in  1  `in_data` valid
- `in_sof`  in  1  start of frame, qualified by `in_valid`; forces this byte to column 0
- `in_ready`  out  1  block can accept a byte this cycle
- `scan_wrap`  in  1  one-cycle pulse when the scan column counter goes 7 -> 0
- `vbuf`  out  64  front buffer; column k at `vbuf[8k+7:8k]`
- `frame_swapped`  out  1  one-cycle pulse after the front buffer is updated
- `wr_ptr`  out  3  next column index to be written

## Operation
- Transfer occurs on a rising edge with `in_valid && in_ready`.
- States: FILL (`in_ready`=1), PENDING (`in_ready`=0).
- FILL, transfer with `in_sof`=1: byte to column 0, `wr_ptr` <- 1. Earlier partial columns keep stale back-buffer contents.
- FILL, transfer with `in_sof`=0: byte to column `wr_ptr`, `wr_ptr` increments.
- Transfer to column 7 completes the frame. The completed frame is the back buffer with the byte merged in. `wr_ptr` wraps to 0 and does not saturate.
- Completion with sync swap: go to PENDING. `scan_wrap` in PENDING: front <- back, pulse `frame_swapped`, return to FILL.
- A `scan_wrap` on the completion edge itself is ignored. The swap waits for the next wrap.
- `scan_wrap` in FILL has no effect.
- `in_data` and `in_sof` are ignored when no transfer occurs.
- Reset: `vbuf`=0, back buffer=0, `wr_ptr`=0, state FILL, `frame_swapped`=0.
- `in_ready`=0 while `rst` is high and 1 on the first cycle after.
- Reset mid-frame or in PENDING discards the partial or pending frame and clears the front buffer.

## Timing
- `in_ready` is a combinational decode of state only and never depends on `in_valid`.
- Sync swap: `vbuf` changes on the edge sampling `scan_wrap`=1 in PENDING. `frame_swapped` is high for the following cycle. `in_ready` returns high in that same cycle.
- Non-sync swap: `vbuf` changes on the edge that accepts the column-7 byte. `frame_swapped` is high the next cycle. `in_ready` stays 1, giving back-to-back frames at one byte per cycle.
- `vbuf` changes only on swap edges or reset.

## Configuration
- `VBUF_WRITER_SYNC_SWAP_EN` defined (default build): PENDING state exists and swaps align to `scan_wrap` as above.
- Undefined: no PENDING state; swap on frame completion. `scan_wrap` is unused (tied off, lint waived).

## Structure
- `vbuf_pkg` holds `FRAME_COLS`=8, `COL_BITS`=8, `VBUF_W`=64, `PTR_W`=3, and the `vbuf_wr_state_t` enum (FILL, PENDING).
- The scan column decoder and data mux import the same constants.
- One sub-module: `vbuf_bank`, a 64-bit register with byte-lane write enable by column index and whole-word load. It is instantiated twice (back, front).

## Test plan
- Reset, then send 0x01,0x02,...,0x08 with valid held, then `scan_wrap` 5 cycles later -> `in_ready` low for 5 cycles. `vbuf`=0x0807060504030201 after the wrap edge. One `frame_swapped` pulse.
- Send 3 bytes, then a byte 0xAA with `in_sof`=1, then 7 more bytes 0x11..0x77, then wrap -> column 0 = 0xAA, column 7 = 0x77. `wr_ptr` sequence 0,1,2,3,1,2,...,7,0.
- `scan_wrap` asserted on the same edge as the column-7 byte -> no swap. The swap occurs at the next `scan_wrap` pulse.
- Assert `rst` while in PENDING -> `vbuf`=0, `wr_ptr`=0, `in_ready` 0 during reset and 1 after. The pending frame never appears.
- Random `in_valid` gaps with `scan_wrap` pulsing every 8 cycles -> every accepted frame appears on `vbuf` exactly once, in order. `vbuf` never changes except on swap edges.
- Macro undefined, 16 consecutive bytes -> `in_ready` constantly 1. Two `frame_swapped` pulses, 8 cycles apart. `vbuf` updated on each column-7 accept edge.
